// File: rtl/infer_seq_pkg.sv
// rtl/infer_seq_pkg.sv - shared state encoding and defaults for the inference layer sequencer
package infer_seq_pkg;

    localparam int DEF_NUM_LAYERS = 3;
    localparam int DEF_TIMEOUT    = 4096;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_C_ST   = 4'd2,
        ST_C_WAIT = 4'd3,
        ST_W_ST   = 4'd4,
        ST_W_WAIT = 4'd5,
        ST_NEXT   = 4'd6,
        ST_DONE   = 4'd7,
        ST_ERR    = 4'd8
    } seq_state_t;

    // States in which the sequencer waits on the datapath and the watchdog runs
    function automatic logic is_wait_state(input seq_state_t s);
        return (s == ST_LOAD) || (s == ST_C_WAIT) || (s == ST_W_WAIT);
    endfunction

endpackage

// File: rtl/seq_wdog.sv
// rtl/seq_wdog.sv - clear/enable cycle counter flagging expiry at TIMEOUT-1
module seq_wdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;

    assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

    // Clear has priority; the count holds at expiry so it can never wrap back to zero
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/infer_seq_ctrl.sv
// rtl/infer_seq_ctrl.sv - per-image layer sequencer: weight load, compute, writeback per layer
module infer_seq_ctrl
    import infer_seq_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int LAYER_W    = 2,
    parameter int FRAME_W    = 16,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               start_i,
    input  logic               abort_i,
    output logic               wload_req_o,
    input  logic               wload_ack_i,
    output logic               comp_start_o,
    input  logic               comp_done_i,
    output logic               wb_start_o,
    input  logic               buf_wr_done_i,
    output logic [LAYER_W-1:0] layer_idx_o,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic               err_o,
    output logic [FRAME_W-1:0] frame_cnt_o
);

    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic [LAYER_W-1:0] layer_q;
    logic [FRAME_W-1:0] frame_q;
    logic               err_q;
    logic               expired;
    logic               accept_start;

    assign accept_start = (state_q == ST_IDLE) && start_i && !abort_i;
    assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_ERR);
    assign layer_idx_o  = layer_q;
    assign frame_cnt_o  = frame_q;
    assign err_o        = err_q;

    // Any state change restarts the watchdog, so every wait state is entered with a zero count
    seq_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .clr_i     (state_d != state_q),
        .en_i      (is_wait_state(state_q)),
        .expired_o (expired)
    );

    // Next-state and strobe decode; abort dominates, awaited input beats timeout expiry
    always_comb begin
        state_d      = state_q;
        wload_req_o  = 1'b0;
        comp_start_o = 1'b0;
        wb_start_o   = 1'b0;
        frame_done_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                wload_req_o = 1'b1;
                if (abort_i)          state_d = ST_IDLE;
                else if (wload_ack_i) state_d = ST_C_ST;
                else if (expired)     state_d = ST_ERR;
            end
            ST_C_ST: begin
                comp_start_o = 1'b1;
                state_d      = abort_i ? ST_IDLE : ST_C_WAIT;
            end
            ST_C_WAIT: begin
                if (abort_i)          state_d = ST_IDLE;
                else if (comp_done_i) state_d = ST_W_ST;
                else if (expired)     state_d = ST_ERR;
            end
            ST_W_ST: begin
                wb_start_o = 1'b1;
                state_d    = abort_i ? ST_IDLE : ST_W_WAIT;
            end
            ST_W_WAIT: begin
                if (abort_i)            state_d = ST_IDLE;
                else if (buf_wr_done_i) state_d = (layer_q == LAST_LAYER) ? ST_DONE : ST_NEXT;
                else if (expired)       state_d = ST_ERR;
            end
            ST_NEXT: begin
                state_d = abort_i ? ST_IDLE : ST_LOAD;
            end
            ST_DONE: begin
                frame_done_o = !abort_i;
                state_d      = ST_IDLE;
            end
            ST_ERR: begin
                if (abort_i) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Layer index, completed-frame counter and sticky error flag
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            layer_q <= '0;
            frame_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept_start) begin
                layer_q <= '0;
            end else if ((state_q == ST_NEXT) && (state_d == ST_LOAD)) begin
                layer_q <= layer_q + 1'b1;
            end
            if (frame_done_o) begin
                frame_q <= frame_q + 1'b1;
            end
            if (accept_start) begin
                err_q <= 1'b0;
            end else if (state_d == ST_ERR) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
